// File: rtl/mod_exp_initiator.sv
// Modular exponentiation initiator: LSB-first square-and-multiply that
// issues every product to an external responder. Option: MOD_EXP_SKIP_ZERO_EN.
module mod_exp_initiator #(
  parameter int WIDTH = 256,
  parameter int K_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_exp,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_mp_start,
  output logic [WIDTH:0]   o_mp_n,
  output logic [WIDTH:0]   o_mp_a,
  output logic [WIDTH:0]   o_mp_b,
  output logic [K_W-1:0]   o_mp_k,
  input  logic [WIDTH:0]   i_mp_result,
  input  logic             i_mp_done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK,
    S_ISS_MUL,
    S_WAIT_MUL,
    S_SQR_CHK,
    S_ISS_SQR,
    S_WAIT_SQR,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_exp_sh;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_mp_start;
  logic [WIDTH:0]   r_mp_n;
  logic [WIDTH:0]   r_mp_a;
  logic [WIDTH:0]   r_mp_b;
  logic [K_W-1:0]   r_mp_k;

  logic w_last;
  logic w_empty;
  logic w_unused;

  // w_last: the bit under exp_sh[0] is the final one to process
`ifdef MOD_EXP_SKIP_ZERO_EN
  assign w_last  = (r_exp_sh[WIDTH-1:1] == '0);
  assign w_empty = (r_exp_sh == '0);
`else
  assign w_last  = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_empty = 1'b0;
`endif

  assign w_unused = i_mp_result[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_m        <= '0;
      r_t        <= '0;
      r_exp_sh   <= '0;
      r_bit_cnt  <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_mp_start <= 1'b0;
      r_mp_n     <= '0;
      r_mp_a     <= '0;
      r_mp_b     <= '0;
      r_mp_k     <= '0;
    end else begin
      r_mp_start <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mp_n    <= {1'b0, i_n};
            r_mp_k    <= K_W'(WIDTH);
            r_exp_sh  <= i_exp;
            r_t       <= i_base;
            r_m       <= (i_n == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_bit_cnt <= '0;
            r_state   <= S_CHK;
          end
        end
        S_CHK: begin
          if (w_empty) begin
            r_result <= r_m;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_exp_sh[0]) begin
            r_mp_start <= 1'b1;
            r_mp_a     <= {1'b0, r_m};
            r_mp_b     <= {1'b0, r_t};
            r_state    <= S_ISS_MUL;
          end else if (!w_last) begin
            r_mp_start <= 1'b1;
            r_mp_a     <= {1'b0, r_t};
            r_mp_b     <= {1'b0, r_t};
            r_state    <= S_ISS_SQR;
          end else begin
            r_state <= S_NEXT;
          end
        end
        S_ISS_MUL: r_state <= S_WAIT_MUL;
        S_WAIT_MUL: begin
          if (i_mp_done) begin
            r_m     <= i_mp_result[WIDTH-1:0];
            r_state <= S_SQR_CHK;
          end
        end
        S_SQR_CHK: begin
          if (!w_last) begin
            r_mp_start <= 1'b1;
            r_mp_a     <= {1'b0, r_t};
            r_mp_b     <= {1'b0, r_t};
            r_state    <= S_ISS_SQR;
          end else begin
            r_state <= S_NEXT;
          end
        end
        S_ISS_SQR: r_state <= S_WAIT_SQR;
        S_WAIT_SQR: begin
          if (i_mp_done) begin
            r_t     <= i_mp_result[WIDTH-1:0];
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          r_exp_sh  <= r_exp_sh >> 1;
          r_bit_cnt <= r_bit_cnt + CW'(1);
          if (w_last) begin
            r_result <= r_m;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_CHK;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_result   = r_result;
  assign o_done     = r_done;
  assign o_mp_start = r_mp_start;
  assign o_mp_n     = r_mp_n;
  assign o_mp_a     = r_mp_a;
  assign o_mp_b     = r_mp_b;
  assign o_mp_k     = r_mp_k;

endmodule

// File: tb/tb_mod_exp_initiator.sv
// Bench for mod_exp_initiator: behavioural responder with programmable
// latency, directed and random operations against an arithmetic model.
`timescale 1ns/1ps
module tb_mod_exp_initiator;

  localparam int W      = 64;
  localparam int KW     = 11;
  localparam int BUDGET = 25000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  base = '0;
  logic [W-1:0]  ex = '0;
  logic [W-1:0]  n = '0;
  logic [W-1:0]  o_result;
  logic          o_done;
  logic          o_mp_start;
  logic [W:0]    o_mp_n;
  logic [W:0]    o_mp_a;
  logic [W:0]    o_mp_b;
  logic [KW-1:0] o_mp_k;
  logic [W:0]    mp_result;
  logic          mp_done;

  logic          rsp_done = 1'b0;
  logic [W:0]    rsp_res = '0;
  logic          spur_done = 1'b0;
  logic [W:0]    spur_res = '0;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int lat_lo = 67;
  int lat_hi = 67;
  logic [W-1:0] last_res = '0;

  assign mp_done   = rsp_done | spur_done;
  assign mp_result = rsp_done ? rsp_res : spur_res;

  always #5 clk = ~clk;

  mod_exp_initiator #(.WIDTH(W), .K_W(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_base      (base),
    .i_exp       (ex),
    .i_n         (n),
    .o_result    (o_result),
    .o_done      (o_done),
    .o_mp_start  (o_mp_start),
    .o_mp_n      (o_mp_n),
    .o_mp_a      (o_mp_a),
    .o_mp_b      (o_mp_b),
    .o_mp_k      (o_mp_k),
    .i_mp_result (mp_result),
    .i_mp_done   (mp_done)
  );

  // MSB-first exponentiation with plain wide arithmetic
  function automatic logic [W-1:0] ref_modexp(
    input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] nn);
    logic [2*W-1:0] r, bb, mm;
    mm = {{W{1'b0}}, nn};
    bb = {{W{1'b0}}, b};
    r  = 1 % mm;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_reqs(input logic [W-1:0] e);
    int pop, top;
    pop = $countones(e);
    top = -1;
    for (int i = 0; i < W; i++) if (e[i]) top = i;
`ifdef MOD_EXP_SKIP_ZERO_EN
    return (top < 0) ? 0 : pop + top;
`else
    return pop + W - 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs,
                     input logic [W:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_result"}, {1'b0, o_result}, '0);
    chk({tag, "_ctl"}, {63'd0, o_done, o_mp_start}, '0);
    chk({tag, "_mp_n"}, o_mp_n, '0);
    chk({tag, "_mp_a"}, o_mp_a, '0);
    chk({tag, "_mp_b"}, o_mp_b, '0);
    chk({tag, "_mp_k"}, {54'd0, o_mp_k}, '0);
  endtask

  // Responder: a*b mod N after L cycles; checks operand stability
  initial begin : responder
    bit busy;
    int rem;
    logic [W:0] ca, cb, cn;
    logic [KW-1:0] ck;
    logic [2*W+1:0] p;
    busy = 0;
    rem = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        rsp_done = 1'b0;
      end else if (rsp_done) begin
        rsp_done = 1'b0;
      end else if (busy) begin
        checks++;
        assert (o_mp_a === ca && o_mp_b === cb && o_mp_n === cn &&
                o_mp_k === ck && o_mp_start === 1'b0) else begin
          errors++;
          $error("FAIL mp_stable observed a=%0h b=%0h st=%0b expected a=%0h b=%0h st=0",
                 o_mp_a, o_mp_b, o_mp_start, ca, cb);
        end
        rem--;
        if (rem <= 0) begin
          p = ca * cb;
          p = p % cn;
          rsp_res = p[W:0];
          rsp_done = 1'b1;
          busy = 0;
        end
      end else if (o_mp_start === 1'b1) begin
        ca = o_mp_a;
        cb = o_mp_b;
        cn = o_mp_n;
        ck = o_mp_k;
        req_cnt++;
        rem = (lat_lo == lat_hi) ? lat_lo : int'($urandom_range(lat_hi, lat_lo));
        busy = 1;
      end
    end
  end

  // Called on a negedge; returns on the negedge after o_done
  task automatic do_op(input logic [W-1:0] b, input logic [W-1:0] e,
                       input logic [W-1:0] nn, input bit spur,
                       input bit start_at_done);
    logic [W-1:0] exp_r;
    int exp_req, cyc;
    bit seen;
    exp_r = ref_modexp(b, e, nn);
    exp_req = ref_reqs(e);
    req_cnt = 0;
    base = b;
    ex = e;
    n = nn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < BUDGET) begin
      if (o_done === 1'b1) begin
        seen = 1;
      end else begin
        chk("result_hold", {1'b0, o_result}, {1'b0, last_res});
        if (spur && cyc == 0) begin
          spur_done = 1'b1;
          spur_res = {$urandom, $urandom, 1'b1};
        end
        if (spur && cyc == 1) spur_done = 1'b0;
        if (spur && (cyc == 20 || cyc == 45)) begin
          base = {$urandom, $urandom};
          ex = {$urandom, $urandom};
          n = {$urandom, $urandom};
          start = 1'b1;
        end
        if (spur && (cyc == 21 || cyc == 46)) start = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", {64'd0, seen}, 65'd1);
    if (seen) begin
      chk("result", {1'b0, o_result}, {1'b0, exp_r});
      chk("req_count", 65'(req_cnt), 65'(exp_req));
      if (start_at_done) begin
        base = 64'd2;
        ex = 64'd3;
        n = 64'd11;
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_width", {64'd0, o_done}, '0);
      last_res = exp_r;
    end
  endtask

  initial begin
    logic [W-1:0] rb, re, rn;
    int cyc;

    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    lat_lo = 67; lat_hi = 67;
    do_op(64'd4, 64'd13, 64'd497, 0, 0);

    lat_lo = 3; lat_hi = 3;
    do_op(64'd9, 64'd0, 64'd11, 0, 0);
    do_op(64'd9, 64'd0, 64'd1, 0, 0);

    lat_lo = 1; lat_hi = 300;
    do_op(64'd2, 64'd10, 64'd1000, 0, 0);

    // Spurious responder done and start pulses
    lat_lo = 4; lat_hi = 4;
    spur_done = 1'b1;
    spur_res = 65'h1_2345;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) begin
      chk("idle_spur_start", {64'd0, o_mp_start}, '0);
      chk("idle_spur_res", {1'b0, o_result}, {1'b0, last_res});
      @(negedge clk);
    end
    do_op(64'd5, 64'h1B, 64'd97, 1, 0);
    do_op(64'd7, 64'h29, 64'd101, 0, 1);
    repeat (5) begin
      chk("start_at_done_ignored", {64'd0, o_mp_start}, '0);
      @(negedge clk);
    end

    // Reset during the first square wait
    lat_lo = 67; lat_hi = 67;
    req_cnt = 0;
    base = 64'd4; ex = 64'd13; n = 64'd497;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (req_cnt < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_wait_sqr", 65'(req_cnt), 65'd2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outs("mid_reset");
    repeat (3) begin
      @(negedge clk);
      chk_zero_outs("reset_window");
    end
    rst_n = 1'b1;
    last_res = '0;
    @(negedge clk);
    chk("post_reset_idle", {64'd0, o_mp_start}, '0);
    do_op(64'd4, 64'd13, 64'd497, 0, 0);

    // Back-to-back: do_op returns on the cycle after o_done
    lat_lo = 5; lat_hi = 5;
    do_op(64'd3, 64'd5, 64'd7, 0, 0);

    lat_lo = 1; lat_hi = 8;
    repeat (3) begin
      rn = {$urandom, $urandom} | 64'd2;
      rb = {$urandom, $urandom} % rn;
      re = {$urandom, $urandom} >> $urandom_range(40, 0);
      do_op(rb, re, rn, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
